sik_thread_stack: RTL
=====================

// Module: sik_thread_stack
// PURPOSE
//  Parametrised multi-thread operand-stack engine for the SIK pipelined core.
//  Holds one private data stack per hardware thread, generalising the fixed two-thread sp1/sp2 scheme.
//  Executes stack-side SIK ops with an integrated ALU: push, pop, dup, add, lt, sub, and, or, xor.
//  Sits between decode and writeback; one op is accepted per handshake, tagged by thread id.
// PARAMETERS
//  WIDTH     16   data word width
//  DEPTH     256  entries per thread stack; power of 2, >=4
//  NTHREADS  2    number of thread contexts; >=1
//  TIDW      derived: max(1,$clog2(NTHREADS))
//  CNTW      derived: $clog2(DEPTH)+1
// PORTS
//  clk        in   1         clock; all state updates on posedge
//  reset      in   1         asynchronous, active-low reset
//  op_valid   in   1         op request valid
//  op_ready   out  1         engine can accept an op this cycle
//  op_tid     in   TIDW      thread selecting which stack
//  op_code    in   4         0000 nop,0001 add,0010 lt,0011 sub,0100 and,0101 or,0110 xor,0111 dup,1000 push,1010 pop
//  op_data    in   WIDTH     push operand
//  clr_err    in   NTHREADS  per-thread sticky-fault clear
//  rsp_valid  out  1         one-cycle response strobe, one per accepted op
//  rsp_tid    out  TIDW      thread of the response
//  rsp_data   out  WIDTH     pop: popped value; others: new top of stack (0 if empty)
//  rsp_fault  out  1         op rejected; no stack state changed
//  err        out  NTHREADS  sticky fault per thread
// BEHAVIOUR
//  Storage: per thread, tos register + count[CNTW] + array slice of DEPTH-1 words, 1 sync read, 1 write/cycle.
//  Array contents are not reset. count==0 means empty. Entry k is below entry k+1.
//  Reset (reset==0, async): state=IDLE, all count=0, tos=0, err=0, rsp_valid=0, rsp_tid=0, rsp_data=0, rsp_fault=0.
//  Reset mid-op aborts any FETCH; no partial update survives. op_ready = (state==IDLE), so it is 1 out of reset.
//  Accept = op_valid & op_ready at posedge. Ops outside the code list act as nop.
//  FSM IDLE: accepting nop/push/dup -> stay IDLE, state updates, rsp_valid next cycle (latency 1).
//   push: if count>0, array[count-1]<=tos; tos<=op_data; count+=1.
//   dup:  array[count-1]<=tos; count+=1; tos unchanged.
//   nop:  no change; rsp_data = tos.
//  FSM IDLE -> FETCH on accepting binary op or pop without fault: issue array read of entry count-2.
//  FETCH (1 cycle, op_ready=0): nos = read data -> IDLE; rsp_valid next cycle (latency 2).
//   pop:    rsp_data<=tos; tos<=nos (tos<=0 if count was 1); count-=1.
//   binary: tos<=alu(nos,tos); count-=1. The lower entry (nos) is in1 and the top (tos) is in2.
//   ALU:    add=in1+in2, sub=in1-in2 (mod 2^WIDTH), and/or/xor bitwise; lt = unsigned in1<in2 ? 1 : 0.
//   pop with count==1 skips the read but still takes the FETCH cycle, giving uniform latency 2.
//  Faults (detected at accept; the op completes in 1 cycle with rsp_fault=1 and no state change):
//   push/dup with count==DEPTH (overflow), pop/dup with count==0, binary op with count<2 (underflow).
//   any op except nop while err[op_tid]==1. A faulting op sets err[op_tid].
//  clr_err[i] clears err[i] each cycle. If a clear and a new fault hit the same thread, set wins.
//  An op in the same cycle as clr_err is checked against the pre-clear err value.
//  Threads are fully independent; an op on thread a never alters thread b's count, tos, err or array slice.
//  rsp_data on fault = current tos of op_tid. rsp_* hold their values when rsp_valid==0.
// TESTING
//  T1 reset=0 mid-FETCH of add -> rsp_valid stays 0, count=0, op_ready=1 after release.
//     The next push 5 returns rsp_data=5.
//  T2 tid0: push 7, push 3, sub -> rsp_data=4 at latency 2. lt -> fault (count=1). err[0]=1.
//     push 1 -> fault. Then clr_err[0] and push 1 -> ok, rsp_data=1.
//  T3 tid0 push 0x8000, push 0x8000, add -> 0x0000.
//     push 0xFFFF, push 1, lt -> 0 (unsigned).
//  T4 fill tid1 with DEPTH pushes (i) -> all ok. The next push faults; err[1]=1, err[0]=0.
//     clr_err, then DEPTH pops return DEPTH-1 down to 0. The next pop faults.
//  T5 interleave tid0/tid1 pushes and pops back-to-back with op_valid held high.
//     op_ready drops exactly during FETCH cycles. Each thread's values come back in LIFO order and never mix.
//  T6 NTHREADS=4, DEPTH=4, WIDTH=8 build: dup on empty faults.
//     push 9, dup, xor -> 0; the 4-deep fill and overflow behave as T4.

Source files
------------

// File: rtl/sik_thread_stack.sv
// sik_thread_stack: multi-thread operand-stack engine with an integrated ALU.
// Each hardware thread owns a private stack: a top-of-stack register, an
// occupancy count and a slice of a shared single-port-style array holding
// the DEPTH-1 entries below the top.
// Ports:
//   clk, reset              clock; asynchronous active-low reset
//   op_valid/op_ready       op handshake (ready only while IDLE)
//   op_tid/op_code/op_data  thread, opcode and push operand
//   clr_err                 per-thread sticky-fault clear
//   rsp_valid/tid/data/fault one-cycle response per accepted op
//   err                     per-thread sticky fault flags
module sik_thread_stack #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 256,
   parameter int NTHREADS = 2,
   parameter int TIDW     = (NTHREADS > 1) ? $clog2(NTHREADS) : 1,
   parameter int CNTW     = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                op_valid,
   output logic                op_ready,
   input  logic [TIDW-1:0]     op_tid,
   input  logic [3:0]          op_code,
   input  logic [WIDTH-1:0]    op_data,
   input  logic [NTHREADS-1:0] clr_err,
   output logic                rsp_valid,
   output logic [TIDW-1:0]     rsp_tid,
   output logic [WIDTH-1:0]    rsp_data,
   output logic                rsp_fault,
   output logic [NTHREADS-1:0] err
);

   localparam int MWORDS = NTHREADS * (DEPTH - 1);
   localparam int AW     = (MWORDS > 1) ? $clog2(MWORDS) : 1;

   localparam logic [3:0] C_ADD  = 4'b0001;
   localparam logic [3:0] C_LT   = 4'b0010;
   localparam logic [3:0] C_SUB  = 4'b0011;
   localparam logic [3:0] C_AND  = 4'b0100;
   localparam logic [3:0] C_OR   = 4'b0101;
   localparam logic [3:0] C_XOR  = 4'b0110;
   localparam logic [3:0] C_DUP  = 4'b0111;
   localparam logic [3:0] C_PUSH = 4'b1000;
   localparam logic [3:0] C_POP  = 4'b1010;

   typedef enum logic {IDLE, FETCH} state_t;

   state_t                         state, state_nxt;
   logic [NTHREADS-1:0][WIDTH-1:0] tos;
   logic [NTHREADS-1:0][CNTW-1:0]  cnt;
   logic [WIDTH-1:0]               mem [MWORDS];
   logic [WIDTH-1:0]               nos;

   // op parked for the FETCH cycle
   logic [TIDW-1:0] f_tid;
   logic [3:0]      f_code;
   logic            f_one;

   logic [WIDTH-1:0]    cur_tos, alu_out;
   logic [CNTW-1:0]     cur_cnt;
   logic                cur_err;
   logic                is_push, is_dup, is_pop, is_bin;
   logic                accept, fault, go_fetch, wr_en, rd_en;
   logic [AW-1:0]       wr_addr, rd_addr;
   logic [NTHREADS-1:0] err_nxt;
   int                  base;

   assign op_ready = (state == IDLE);

   always_comb begin
      cur_tos  = tos[op_tid];
      cur_cnt  = cnt[op_tid];
      cur_err  = err[op_tid];
      is_push  = (op_code == C_PUSH);
      is_dup   = (op_code == C_DUP);
      is_pop   = (op_code == C_POP);
      is_bin   = (op_code >= C_ADD) && (op_code <= C_XOR);
      accept   = op_valid && op_ready;
      // unknown codes are plain nops, so a sticky error does not reject them
      fault    = accept && ((cur_err && (is_push || is_dup || is_pop || is_bin)) ||
                            (is_push && cur_cnt == CNTW'(DEPTH)) ||
                            (is_dup  && (cur_cnt == '0 || cur_cnt == CNTW'(DEPTH))) ||
                            (is_pop  && cur_cnt == '0) ||
                            (is_bin  && cur_cnt < CNTW'(2)));
      go_fetch = accept && !fault && (is_pop || is_bin);
      // the old top sinks into the array on push (non-empty) and dup
      wr_en    = accept && !fault && ((is_push && cur_cnt != '0) || is_dup);
      // a pop of the last entry has nothing below it to read
      rd_en    = go_fetch && (cur_cnt >= CNTW'(2));
      base     = int'(op_tid) * (DEPTH - 1);
      wr_addr  = AW'(base + int'(cur_cnt) - 1);
      rd_addr  = AW'(base + int'(cur_cnt) - 2);
      for (int i = 0; i < NTHREADS; i++)
         err_nxt[i] = (err[i] && !clr_err[i]) || (fault && int'(op_tid) == i);
   end

   // nos is in1, top of stack is in2
   always_comb begin
      alu_out = '0;
      case (f_code)
         C_ADD:   alu_out = nos + tos[f_tid];
         C_SUB:   alu_out = nos - tos[f_tid];
         C_LT:    alu_out = WIDTH'(nos < tos[f_tid]);
         C_AND:   alu_out = nos & tos[f_tid];
         C_OR:    alu_out = nos | tos[f_tid];
         C_XOR:   alu_out = nos ^ tos[f_tid];
         default: alu_out = '0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (go_fetch) state_nxt = FETCH;
         FETCH:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // array is deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= cur_tos;
      if (rd_en) nos <= mem[rd_addr];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tos       <= '0;
         cnt       <= '0;
         err       <= '0;
         rsp_valid <= 1'b0;
         rsp_tid   <= '0;
         rsp_data  <= '0;
         rsp_fault <= 1'b0;
         f_tid     <= '0;
         f_code    <= '0;
         f_one     <= 1'b0;
      end else begin
         err       <= err_nxt;
         rsp_valid <= 1'b0;
         if (state == FETCH) begin
            rsp_valid  <= 1'b1;
            rsp_fault  <= 1'b0;
            rsp_tid    <= f_tid;
            cnt[f_tid] <= cnt[f_tid] - CNTW'(1);
            if (f_code == C_POP) begin
               rsp_data   <= tos[f_tid];
               tos[f_tid] <= f_one ? '0 : nos;
            end else begin
               rsp_data   <= alu_out;
               tos[f_tid] <= alu_out;
            end
         end else if (accept) begin
            if (fault) begin
               rsp_valid <= 1'b1;
               rsp_fault <= 1'b1;
               rsp_tid   <= op_tid;
               rsp_data  <= cur_tos;
            end else if (go_fetch) begin
               f_tid  <= op_tid;
               f_code <= op_code;
               f_one  <= (cur_cnt == CNTW'(1));
            end else begin
               rsp_valid <= 1'b1;
               rsp_fault <= 1'b0;
               rsp_tid   <= op_tid;
               rsp_data  <= cur_tos;
               if (is_push) begin
                  tos[op_tid] <= op_data;
                  cnt[op_tid] <= cur_cnt + CNTW'(1);
                  rsp_data    <= op_data;
               end else if (is_dup) begin
                  cnt[op_tid] <= cur_cnt + CNTW'(1);
               end
            end
         end
      end
   end

endmodule
